// File: rtl/cache_pkg.sv
// Shared widths and state encoding for the cache line / burst memory adaptor.
// Imported by cacheline_adaptor.
package cache_pkg;

    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int ADDR_W   = 32;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat burst memory port.
// Ports: clk, rst_n; cache side line_i/address_i/read_i/write_i/line_o/resp_o;
// memory side burst_i/burst_o/address_o/read_o/write_o/resp_i.
module cacheline_adaptor
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] line_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    adaptor_state_t    r_state;
    adaptor_state_t    w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_wline;
    logic [LINE_W-1:0] r_rline;
    logic [ADDR_W-1:0] r_addr;
    logic              r_read;
    logic              r_write;
    logic              r_resp;
    logic              w_burst;
    logic              w_beat;
    logic              w_last;
    logic              w_start;

    assign w_burst = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_beat  = w_burst && resp_i;
    assign w_last  = w_beat && (r_cnt == CNT_W'(BEATS - 1));
    assign w_start = (r_state == IDLE) && (read_i || write_i);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                // write has priority if the cache raises both
                if (write_i)
                    w_next = WR_BURST;
                else if (read_i)
                    w_next = RD_BURST;
            end
            RD_BURST, WR_BURST: begin
                if (w_last)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_read  <= (w_next == RD_BURST);
            r_write <= (w_next == WR_BURST);
            r_resp  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rline <= '0;
        end else if (w_start) begin
            r_addr <= address_i;
            r_cnt  <= '0;
            if (write_i)
                r_wline <= line_i;
        end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == RD_BURST)
                r_rline[BEAT_W*r_cnt +: BEAT_W] <= burst_i;
        end
    end

    assign line_o    = r_rline;
    assign burst_o   = r_wline[BEAT_W*r_cnt +: BEAT_W];
    assign address_o = {r_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: directed cases plus random
// fills and write-backs against a line-level reference model.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst_n;
    logic [255:0] line_i;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
        int           t0;
        int           lat;
    } sb_t;

    sb_t         sb[$];
    logic [63:0] wq[$];
    bit          pat_q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          prev_resp = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic make_pat(input int stall_pct);
        int ones = 0;
        bit b;
        pat_q.delete();
        while (ones < 4) begin
            b = ($urandom % 100) >= stall_pct;
            pat_q.push_back(b);
            if (b) ones++;
        end
    endtask

    // Called just after a falling edge; returns at the falling edge of the
    // resp_o cycle with the request already dropped.
    task automatic run_txn(input bit wr, input bit rd,
                           input logic [31:0] a, input logic [255:0] ln);
        sb_t e;
        int  stalls = 0;
        int  k = 0;
        int  idx = 0;
        int  budget = 0;
        foreach (pat_q[i])
            if (!pat_q[i]) stalls++;
        e.wr   = wr;
        e.addr = {a[31:5], 5'b0};
        e.line = ln;
        e.t0   = cyc;
        e.lat  = 5 + stalls;
        sb.push_back(e);
        if (wr)
            for (int i = 0; i < 4; i++)
                wq.push_back(ln[64*i +: 64]);
        read_i    = rd;
        write_i   = wr;
        address_i = a;
        line_i    = wr ? ln : rand_line();
        resp_i    = 0;
        burst_i   = {$urandom, $urandom};
        forever begin
            @(negedge clk);
            budget++;
            burst_i = {$urandom, $urandom};
            if (resp_o) begin
                read_i  = 0;
                write_i = 0;
                resp_i  = 0;
                break;
            end
            if (budget > 60) begin
                fail("txn_timeout");
                read_i  = 0;
                write_i = 0;
                resp_i  = 0;
                break;
            end
            if (read_o || write_o) begin
                resp_i = (idx < pat_q.size()) ? pat_q[idx] : 1'b1;
                idx++;
                if (resp_i && !wr && k < 4) begin
                    burst_i = ln[64*k +: 64];
                    k++;
                end
            end else begin
                resp_i = $urandom % 2;
            end
        end
    endtask

    // Monitor: samples between edges, pops the scoreboard on resp_o.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_resp = 0;
            end else begin
                if (prev_resp)
                    chk("resp_single", 256'(resp_o), 256'(0));
                prev_resp = resp_o;
                if ((read_o || write_o) && sb.size() > 0) begin
                    chk("address_o", 256'(address_o), 256'(sb[0].addr));
                    chk("read_o", 256'(read_o), 256'(!sb[0].wr));
                    chk("write_o", 256'(write_o), 256'(sb[0].wr));
                end
                if (write_o && resp_i) begin
                    if (wq.size() == 0)
                        fail("extra_wbeat");
                    else
                        chk("burst_o", 256'(burst_o), 256'(wq.pop_front()));
                end
                if (resp_o) begin
                    if (sb.size() == 0) begin
                        fail("unexpected_resp");
                    end else begin
                        e = sb.pop_front();
                        chk("latency", 256'(cyc - e.t0), 256'(e.lat));
                        if (!e.wr)
                            chk("line_o", line_o, e.line);
                    end
                end
            end
        end
    end

    initial begin
        int     kind;
        int     budget;
        logic [255:0] ln;
        rst_n     = 0;
        read_i    = 0;
        write_i   = 0;
        line_i    = '0;
        address_i = '0;
        burst_i   = '0;
        resp_i    = 0;
        #3;
        chk("rst_line_o", line_o, 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_address_o", 256'(address_o), 256'(0));
        chk("rst_strobes", 256'({read_o, write_o, resp_o}), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // directed fill
        pat_q = {1'b1, 1'b1, 1'b1, 1'b1};
        run_txn(0, 1, 32'h0000_1234,
                {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111});
        @(negedge clk);

        // directed write-back, then back-to-back fill
        pat_q = {1'b1, 1'b1, 1'b1, 1'b1};
        run_txn(1, 0, 32'h8000_00FF,
                {64'hD3D3_0003_3333_DDDD, 64'hD2D2_0002_2222_DDDD,
                 64'hD1D1_0001_1111_DDDD, 64'hD0D0_0000_0000_DDDD});
        @(negedge clk);

        // stalled fill: resp_o lands in cycle 8
        pat_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(0, 1, 32'h0000_4000, rand_line());
        @(negedge clk);

        // simultaneous request: write wins
        make_pat(30);
        run_txn(1, 1, 32'h1357_9BDF, rand_line());
        @(negedge clk);

        // reset after two read beats
        read_i    = 1;
        address_i = 32'h0000_5A40;
        budget    = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!read_o && budget < 10);
        if (!read_o) fail("rd_start_timeout");
        resp_i  = 1;
        burst_i = {$urandom, $urandom};
        @(negedge clk);
        burst_i = {$urandom, $urandom};
        @(negedge clk);
        rst_n   = 0;
        resp_i  = 0;
        read_i  = 0;
        #1;
        chk("mid_rst_line_o", line_o, 256'(0));
        chk("mid_rst_address_o", 256'(address_o), 256'(0));
        chk("mid_rst_strobes", 256'({read_o, write_o, resp_o}), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_resp", 256'(resp_o), 256'(0));
        end
        pat_q = {1'b1, 1'b1, 1'b1, 1'b1};
        run_txn(0, 1, 32'h0000_5A40, rand_line());
        @(negedge clk);

        // random mix
        for (int n = 0; n < 30; n++) begin
            kind = $urandom % 5;
            ln   = rand_line();
            make_pat($urandom % 50);
            if (kind < 2)
                run_txn(0, 1, $urandom, ln);
            else if (kind < 4)
                run_txn(1, 0, $urandom, ln);
            else
                run_txn(1, 1, $urandom, ln);
            repeat (1 + ($urandom % 3)) @(negedge clk);
        end

        budget = 0;
        while ((sb.size() > 0 || wq.size() > 0) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() > 0 || wq.size() > 0)
            fail("scoreboard_not_drained");
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
